// File: rtl/bench_run_sequencer_pkg.sv
// Shared state encoding and finish-condition helper for the bench run sequencer.
package bench_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_RST  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Bits outside 'valid' are neutral: treated as set for the all-mode AND, clear for the any-mode OR.
    function automatic logic finish_cond(input logic mode_all,
                                         input logic [31:0] vec,
                                         input logic [31:0] valid);
        if (mode_all) return &(vec | ~valid);
        return |(vec & valid);
    endfunction

endpackage

// File: rtl/bench_run_sequencer_if.sv
// Control/status and DUT-facing signals of the bench run sequencer.
interface bench_run_sequencer_if #(
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 32
);
    logic                start;
    logic                abort;
    logic                dut_reset;
    logic [CHANNELS-1:0] dut_run_req;
    logic [CHANNELS-1:0] dut_finish;
    logic                busy;
    logic                done;
    logic                finished;
    logic                timeout;
    logic [CHANNELS-1:0] finish_mask;
    logic [CNT_W-1:0]    cycles;

    modport slave (
        input  start, abort, dut_finish,
        output dut_reset, dut_run_req, busy, done, finished, timeout, finish_mask, cycles
    );

    modport master (
        output start, abort, dut_finish,
        input  dut_reset, dut_run_req, busy, done, finished, timeout, finish_mask, cycles
    );
endinterface

// File: rtl/bench_run_sequencer_counter.sv
// Saturating up-counter with synchronous clear (priority) and enable.
module bench_seq_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bench_run_sequencer.sv
// Harness controller: start -> DUT reset window -> run with finish collection, timeout and abort.
module bench_run_sequencer
    import bench_seq_pkg::*;
#(
    parameter int          CHANNELS  = 1,
    parameter int          RST_DELAY = 4,
    parameter int          RST_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int          CNT_W     = 32,
    parameter bit          MODE_ALL  = 1'b1
) (
    input logic                  clk,
    input logic                  reset,
    bench_run_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] WIDTH_LAST   = CNT_W'(RST_WIDTH - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      CH_VALID     = 32'((64'd1 << CHANNELS) - 64'd1);

    state_e              state, state_d;
    logic                start_q;
    logic [CNT_W-1:0]    phase_cnt;
    logic [CHANNELS-1:0] seen, mask_d;
    logic                cond, expiry;
    logic                dut_reset_d, run_req_d, busy_d, done_d, finished_d, timeout_d;
    logic                phase_clr, phase_en, run_clr, run_en;

    assign seen   = bus.finish_mask | bus.dut_finish;
    assign cond   = finish_cond(MODE_ALL, 32'(seen), CH_VALID);
    assign expiry = (bus.cycles == TIMEOUT_LAST);

    bench_seq_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (phase_clr),
        .en    (phase_en),
        .count (phase_cnt)
    );

    bench_seq_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .count (bus.cycles)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state;
        mask_d     = bus.finish_mask;
        finished_d = bus.finished;
        timeout_d  = bus.timeout;

        unique case (state)
            ST_IDLE: if (start_q) state_d = ST_PRE;
            ST_PRE:  if (phase_cnt == DELAY_LAST) state_d = ST_RST;
            ST_RST:  if (phase_cnt == WIDTH_LAST) state_d = ST_RUN;
            ST_RUN: begin
                mask_d = seen;
                if (cond) begin
                    state_d    = ST_DONE;
                    finished_d = 1'b1;
                end else if (bus.abort) begin
                    state_d = ST_DONE;
                end else if (expiry) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_q) begin
                    state_d    = ST_PRE;
                    mask_d     = '0;
                    finished_d = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        dut_reset_d = (state_d == ST_RST);
        run_req_d   = (state_d == ST_RUN);
        busy_d      = (state_d inside {ST_PRE, ST_RST, ST_RUN});
        done_d      = (state_d == ST_DONE);

        phase_clr = (state_d != state);
        phase_en  = (state inside {ST_PRE, ST_RST});
        run_clr   = (state_d == ST_PRE) && (state != ST_PRE);
        run_en    = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= ST_IDLE;
            start_q         <= 1'b0;
            bus.dut_reset   <= 1'b0;
            bus.dut_run_req <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.finished    <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.finish_mask <= '0;
        end else begin
            state           <= state_d;
            // start is only captured where it can act, so a pulse during a sequence is dropped.
            start_q         <= bus.start && (state inside {ST_IDLE, ST_DONE});
            bus.dut_reset   <= dut_reset_d;
            bus.dut_run_req <= {CHANNELS{run_req_d}};
            bus.busy        <= busy_d;
            bus.done        <= done_d;
            bus.finished    <= finished_d;
            bus.timeout     <= timeout_d;
            bus.finish_mask <= mask_d;
        end
    end

endmodule
